// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: FILL/WASH/DRAIN/SPIN/DRY state machine with
// door-interlocked actuators and a single-slot status write-back to control memory.
module wash_sequencer #(
  parameter int FILL_TIMEOUT  = 20,
  parameter int DRAIN_TIMEOUT = 20,
  parameter int SPIN_TIME     = 6,
  parameter int DRY_TIME      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       control_start,
  input  logic       control_drying,
  input  logic [1:0] control_preset,
  input  logic [7:0] washing_time,
  input  logic       tick,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic       water_empty,
  input  logic       host_wr_req,
  output logic       wr_enb,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       valve_in,
  output logic       pump_out,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       heater_on,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_WASH   = 3'd2,
    S_DRAIN  = 3'd3,
    S_SPIN   = 3'd4,
    S_DRY    = 3'd5,
    S_FINISH = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       pass_q, pass_d;
  logic [1:0] fault_q, fault_d;
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       running_s, paused_s, expired_s, issue_s;

  function automatic logic [7:0] entry_load(input state_t st, input logic [1:0] preset,
                                            input logic [7:0] wtime);
    logic [7:0] val;
    case (st)
      S_FILL:  val = 8'(FILL_TIMEOUT);
      S_WASH:  val = (preset == 2'b01) ? (wtime >> 1) : wtime;
      S_DRAIN: val = 8'(DRAIN_TIMEOUT);
      S_SPIN:  val = 8'(SPIN_TIME);
      S_DRY:   val = 8'(DRY_TIME);
      default: val = 8'd0;
    endcase
    return val;
  endfunction

  // States in which an open door freezes the program
  always_comb begin
    case (state_q)
      S_FILL, S_WASH, S_DRAIN, S_SPIN, S_DRY: running_s = 1'b1;
      default:                                running_s = 1'b0;
    endcase
  end

  assign paused_s  = running_s & ~door_closed;
  assign expired_s = (timer_q == 8'd0);
  // The host owns the memory port whenever it asks; reset suppresses any write-back.
  assign issue_s   = pend_valid_q & ~host_wr_req & ~reset;

  // Next state, timer, pass/fault flags and pending write slot
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (control_start && door_closed) begin
          state_d = S_FILL;
          pass_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (paused_s) begin
          state_d = S_FILL;
        end else if (water_full) begin
          state_d = S_WASH;
        end else if (expired_s) begin
          state_d = S_FAULT;
          fault_d = 2'b01;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WASH: begin
        if (!paused_s && expired_s) state_d = S_DRAIN;
        else                        state_d = S_WASH;
      end
      S_DRAIN: begin
        if (paused_s) begin
          state_d = S_DRAIN;
        end else if (water_empty) begin
          if (control_preset == 2'b11 && !pass_q) begin
            state_d = S_FILL;
            pass_d  = 1'b1;
          end else begin
            state_d = S_SPIN;
          end
        end else if (expired_s) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_SPIN: begin
        if (!paused_s && expired_s) state_d = control_drying ? S_DRY : S_FINISH;
        else                        state_d = S_SPIN;
      end
      S_DRY: begin
        if (!paused_s && expired_s) state_d = S_FINISH;
        else                        state_d = S_DRY;
      end
      S_FINISH: begin
        if (issue_s && pend_addr_q == 2'd0) state_d = S_IDLE;
        else                                state_d = S_FINISH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    if (state_d != state_q) begin
      timer_d = entry_load(state_d, control_preset, washing_time);
    end else if (!paused_s && tick && !expired_s) begin
      timer_d = timer_q - 8'd1;
    end else begin
      timer_d = timer_q;
    end

    // A fresh status write always replaces whatever is still waiting in the slot;
    // in FINISH the start-clear write follows once the status write has gone out.
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (state_d != state_q) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = 2'd3;
      pend_data_d  = {fault_d, 1'b0, pass_d, 1'b0, state_d};
    end else if (state_q == S_FINISH && issue_s && pend_addr_q == 2'd3) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = 2'd0;
      pend_data_d  = {6'b000000, control_drying, 1'b0};
    end else if (issue_s) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= 8'd0;
      pass_q       <= 1'b0;
      fault_q      <= 2'b00;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 2'd0;
      pend_data_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pass_q       <= pass_d;
      fault_q      <= fault_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Actuator decode, forced off whenever the door is open
  always_comb begin
    valve_in   = 1'b0;
    pump_out   = 1'b0;
    motor_on   = 1'b0;
    motor_fast = 1'b0;
    heater_on  = 1'b0;
    if (door_closed) begin
      case (state_q)
        S_FILL:  valve_in = 1'b1;
        S_WASH: begin
          motor_on  = 1'b1;
          heater_on = (control_preset == 2'b10);
        end
        S_DRAIN: pump_out = 1'b1;
        S_SPIN: begin
          motor_on   = 1'b1;
          motor_fast = 1'b1;
          pump_out   = 1'b1;
        end
        S_DRY: begin
          motor_on  = 1'b1;
          heater_on = 1'b1;
        end
        default: valve_in = 1'b0;
      endcase
    end else begin
      valve_in = 1'b0;
    end
  end

  assign wr_enb  = issue_s;
  assign wr_addr = pend_addr_q;
  assign wr_data = pend_data_q;
  assign busy    = (state_q != S_IDLE);
  assign state   = state_q;

endmodule
